// File: rtl/pwm_ramp_ctrl.sv
// Duty/Final_Value sequencer for the PWM generator: ramps duty one LSB per step, updating only on period boundaries.
// Define PWM_RAMP_RETARGET_EN to accept new configs while a ramp is running.
//
// state | meaning
// IDLE  | duty_out at target, config accepted
// RAMP  | stepping duty_out toward target on period boundaries
module pwm_ramp_ctrl #(
  parameter int BITS          = 4,
  parameter int TIMER_BITS    = 4,
  parameter int STEP_DIV_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [BITS:0]            cfg_target,
  input  logic [STEP_DIV_BITS-1:0] cfg_step_div,
  input  logic [TIMER_BITS-1:0]    cfg_final_value,
  output logic [BITS:0]            duty_out,
  output logic [TIMER_BITS-1:0]    final_value_out,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [BITS:0]   FULL      = {1'b1, {BITS{1'b0}}};
  localparam logic [BITS-1:0] SLOT_LAST = '1;

  state_t                   state_q;
  logic [TIMER_BITS-1:0]    tick_q;
  logic [BITS-1:0]          slot_q;
  logic [STEP_DIV_BITS-1:0] step_cnt_q;
  logic [STEP_DIV_BITS-1:0] step_div_q;
  logic [BITS:0]            target_q;
  logic [BITS:0]            duty_q;
  logic [TIMER_BITS-1:0]    fv_q;
  logic [TIMER_BITS-1:0]    pending_fv_q;
  logic                     busy_q;
  logic                     done_q;

  logic          tick;
  logic          boundary;
  logic          accept;
  logic [BITS:0] target_clamped;
  logic [BITS:0] duty_d;

  assign tick           = (tick_q == fv_q);
  assign boundary       = enable && tick && (slot_q == SLOT_LAST);
  assign accept         = cfg_valid && cfg_ready;
  assign target_clamped = (cfg_target > FULL) ? FULL : cfg_target;

`ifdef PWM_RAMP_RETARGET_EN
  assign cfg_ready = 1'b1;
`else
  assign cfg_ready = (state_q == IDLE);
`endif

  always_comb begin
    duty_d = duty_q;
    if (target_q > duty_q) begin
      duty_d = duty_q + 1'b1;
    end else if (target_q < duty_q) begin
      duty_d = duty_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      slot_q       <= '0;
      step_cnt_q   <= '0;
      step_div_q   <= '0;
      target_q     <= '0;
      duty_q       <= '0;
      fv_q         <= '0;
      pending_fv_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Replica of the generator's timer and slot counters
      if (enable) begin
        if (tick) begin
          tick_q <= '0;
          slot_q <= slot_q + 1'b1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end

      // Uses the pending value held before this edge, so an accept on a boundary lands one period later
      if (boundary) begin
        fv_q <= pending_fv_q;
      end

      if (accept) begin
        target_q     <= target_clamped;
        step_div_q   <= cfg_step_div;
        pending_fv_q <= cfg_final_value;
        step_cnt_q   <= '0;
        if (target_clamped == duty_q) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= RAMP;
          busy_q  <= 1'b1;
        end
      end else if ((state_q == RAMP) && boundary) begin
        if (step_cnt_q == step_div_q) begin
          step_cnt_q <= '0;
          duty_q     <= duty_d;
          if (duty_d == target_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end else begin
          step_cnt_q <= step_cnt_q + 1'b1;
        end
      end
    end
  end

  assign duty_out        = duty_q;
  assign final_value_out = fv_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: per-cycle comparison against a period-position model, a ramp table and corner sequences.
// Define PWM_RAMP_RETARGET_EN to build against the retarget variant.
module tb_pwm_ramp_ctrl;
  localparam int BITS = 4;
  localparam int TBW  = 4;
  localparam int SBW  = 8;
  localparam int FULL = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [BITS:0]   cfg_target = '0;
  logic [SBW-1:0]  cfg_step_div = '0;
  logic [TBW-1:0]  cfg_final_value = '0;
  logic [BITS:0]   duty_out;
  logic [TBW-1:0]  final_value_out;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.BITS(BITS), .TIMER_BITS(TBW), .STEP_DIV_BITS(SBW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_target(cfg_target), .cfg_step_div(cfg_step_div), .cfg_final_value(cfg_final_value),
    .duty_out(duty_out), .final_value_out(final_value_out), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: position within the current PWM period plus the ramp bookkeeping
  int m_pos, m_fv, m_duty, m_tgt, m_sdiv, m_pfv, m_scnt;
  bit m_busy, m_done;

  function automatic bit m_ready();
`ifdef PWM_RAMP_RETARGET_EN
    return 1'b1;
`else
    return !m_busy;
`endif
  endfunction

  task automatic model_reset();
    m_pos = 0; m_fv = 0; m_duty = 0; m_tgt = 0; m_sdiv = 0; m_pfv = 0; m_scnt = 0;
    m_busy = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit acc, bnd;
    int old_pfv, t;
    if (!reset) begin
      model_reset();
      return;
    end
    acc = cfg_valid && m_ready();
    bnd = enable && (m_pos == FULL * (m_fv + 1) - 1);
    old_pfv = m_pfv;
    m_done = 0;
    if (enable) m_pos = bnd ? 0 : m_pos + 1;
    if (acc) begin
      t = (int'(cfg_target) > FULL) ? FULL : int'(cfg_target);
      m_tgt = t; m_sdiv = cfg_step_div; m_pfv = cfg_final_value; m_scnt = 0;
      if (t == m_duty) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_busy = 1;
      end
    end else if (m_busy && bnd) begin
      if (m_scnt == m_sdiv) begin
        m_duty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
        m_scnt = 0;
        if (m_duty == m_tgt) begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_scnt++;
      end
    end
    if (bnd) m_fv = old_pfv;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    vectors++;
    if (duty_out !== m_duty[BITS:0] || final_value_out !== m_fv[TBW-1:0] || busy !== m_busy ||
        done !== m_done || cfg_ready !== m_ready()) begin
      miscompares++;
      $display("FAIL model at %0t: duty %0d/%0d fv %0d/%0d busy %b/%b done %b/%b ready %b/%b (got/expected)",
               $time, duty_out, m_duty, final_value_out, m_fv, busy, m_busy, done, m_done, cfg_ready, m_ready());
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic send(input int t, input int s, input int f);
    cfg_valid = 1'b1;
    cfg_target = t[BITS:0];
    cfg_step_div = s[SBW-1:0];
    cfg_final_value = f[TBW-1:0];
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic run_ramp(input int prev, input int budget, output int changes, output int spacing,
                          output int ndone, output int fv_at_done, output bit to);
    int last;
    last = -1; changes = 0; spacing = -1; ndone = 0; to = 1'b1; fv_at_done = 0;
    for (int c = 0; c < budget; c++) begin
      if (int'(duty_out) != prev) begin
        changes++;
        if (last >= 0) spacing = c - last;
        last = c;
        prev = duty_out;
      end
      if (done) begin
        ndone++; to = 1'b0; fv_at_done = final_value_out;
        break;
      end
      step();
    end
    if (!to) begin
      for (int k = 0; k < 4; k++) begin
        step();
        if (done) ndone++;
      end
    end
  endtask

  typedef struct {
    int tgt; int sdiv; int fv;
    int exp_duty; int exp_fv; int exp_changes; int exp_spacing;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int changes, spacing, ndone, fvd, held_duty, held_fv, prev, t;
    bit to, held_busy;

    tbl[0] = '{3, 0, 0, 3, 0, 3, 16};
    tbl[1] = '{0, 0, 0, 0, 0, 3, 16};
    tbl[2] = '{2, 2, 1, 2, 1, 2, 96};
    tbl[3] = '{31, 0, 0, 16, 0, 14, 16};
    tbl[4] = '{14, 1, 2, 14, 2, 2, 96};
    tbl[5] = '{14, 0, 0, 14, 2, 0, -1};

    model_reset();
    #1;
    check("rst_duty", duty_out, 0);
    check("rst_fv", final_value_out, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();
    step();
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step();

    for (int i = 0; i < 6; i++) begin
      prev = duty_out;
      send(tbl[i].tgt, tbl[i].sdiv, tbl[i].fv);
      run_ramp(prev, 3000, changes, spacing, ndone, fvd, to);
      check($sformatf("tbl%0d_timeout", i), to, 0);
      check($sformatf("tbl%0d_duty", i), duty_out, tbl[i].exp_duty);
      check($sformatf("tbl%0d_fv", i), fvd, tbl[i].exp_fv);
      check($sformatf("tbl%0d_changes", i), changes, tbl[i].exp_changes);
      check($sformatf("tbl%0d_spacing", i), spacing, tbl[i].exp_spacing);
      check($sformatf("tbl%0d_done_pulses", i), ndone, 1);
    end

    // Enable hold mid-ramp
    send(8, 0, 1);
    for (int i = 0; i < 100; i++) step();
    check("hold_busy_before", busy, 1);
    held_duty = duty_out; held_fv = final_value_out; held_busy = busy;
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      check("hold_frozen", {duty_out, final_value_out, busy}, {held_duty[BITS:0], held_fv[TBW-1:0], held_busy});
    end
    enable = 1'b1;
    prev = duty_out;
    run_ramp(prev, 3000, changes, spacing, ndone, fvd, to);
    check("hold_timeout", to, 0);
    check("hold_duty", duty_out, 8);

    // Reset pulse mid-ramp
    send(0, 0, 0);
    for (int i = 0; i < 40; i++) step();
    reset = 1'b0;
    #1;
    check("midrst_duty", duty_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cfg_ready, 1);
    check("midrst_fv", final_value_out, 0);
    model_reset();
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();

`ifdef PWM_RAMP_RETARGET_EN
    send(12, 0, 0);
    for (int i = 0; i < 400 && duty_out != 8; i++) step();
    check("retgt_reach8", duty_out, 8);
    send(5, 0, 0);
    prev = duty_out;
    run_ramp(prev, 3000, changes, spacing, ndone, fvd, to);
    check("retgt_timeout", to, 0);
    check("retgt_duty", duty_out, 5);
    check("retgt_changes", changes, 3);
`endif

    // Randomized configs with random enable gaps
    for (int r = 0; r < 6; r++) begin
      t = $urandom_range(0, 20);
      send(t, $urandom_range(0, 2), $urandom_range(0, 3));
      to = 1'b1;
      for (int c = 0; c < 8000; c++) begin
        if (done) begin
          to = 1'b0;
          break;
        end
        enable = ($urandom_range(0, 9) != 0);
        step();
      end
      enable = 1'b1;
      check("rand_timeout", to, 0);
      check("rand_duty", duty_out, (t > FULL) ? FULL : t);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Controller that sequences the PWM generator's `duty` and `Final_Value` inputs.
- Accepts a target duty, step rate and timer reload value through a valid/ready handshake.
- Walks `duty_out` one LSB at a time toward the target, changing outputs only on PWM period boundaries, so there are no glitched or truncated periods.
- Sits between the register/config layer and the PWM generator, and tracks the generator's period with an internal replica of its timer and slot counters.

Parameters:
- BITS, 4, PWM slot-counter width; `duty` is BITS+1 bits, full-on value is 2^BITS.
- TIMER_BITS, 4, timer reload width, matching the PWM generator.
- STEP_DIV_BITS, 8, width of the periods-per-step divider.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = counters and ramp advance; 0 = everything frozen, outputs held.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  controller can accept config.
- cfg_target  in  BITS+1  target duty; values above 2^BITS are clamped to 2^BITS.
- cfg_step_div  in  STEP_DIV_BITS  PWM periods per duty step is cfg_step_div+1.
- cfg_final_value  in  TIMER_BITS  timer reload value for the PWM generator.
- duty_out  out  BITS+1  to PWM `duty`.
- final_value_out  out  TIMER_BITS  to PWM `Final_Value`.
- busy  out  1  ramp in progress.
- done  out  1  one-cycle pulse when duty_out reaches the target.

Behaviour:
- Reset values (asynchronous, `reset` low):
  - duty_out=0, final_value_out=0, busy=0, done=0.
  - Tick counter, slot counter and step counter = 0.
  - state=IDLE, so cfg_ready=1 immediately after reset.
- Period tracking (only while enable=1):
  - Tick counter counts 0..final_value_out, then wraps to 0.
  - tick is asserted when the tick counter equals final_value_out.
  - On each tick the BITS-wide slot counter increments and wraps modulo 2^BITS.
  - Boundary = tick AND slot counter = 2^BITS-1. Period length is 2^BITS*(final_value_out+1) cycles.
- Handshake:
  - Transfer occurs when cfg_valid & cfg_ready are both high at a rising clk edge.
  - cfg_ready = (state==IDLE), registered-state based with no combinational path from cfg_valid.
  - On accept, the controller latches target (clamped), step_div and pending_fv, and clears the step counter.
- IDLE:
  - On accept with clamped target == duty_out: stay in IDLE. final_value_out takes pending_fv at the next boundary. done pulses in the cycle after accept.
  - On accept with target != duty_out: go to RAMP next cycle; busy=1.
- RAMP, at each boundary:
  - final_value_out <= pending_fv.
  - If step counter == step_div: duty_out moves ±1 toward the target and the step counter resets to 0.
  - Otherwise the step counter increments.
  - When the updated duty_out equals the target: go to IDLE, busy=0, and done=1 for exactly the next cycle.
- Width rules: duty_out saturates within 0..2^BITS and never wraps. The step counter is STEP_DIV_BITS wide.
- Latency: the first duty change occurs at the (step_div+1)-th boundary after accept.
- enable=0 mid-ramp: counters, duty_out and state are held. The ramp resumes exactly where it stopped.
- Reset asserted mid-ramp: immediate return to reset values; the latched target is discarded.
- The boundary and accept cannot occur in the same cycle while in RAMP. If they coincide in IDLE, the accept is applied and the new pending_fv is used at the following boundary.

Optional Feature:
- Macro: PWM_RAMP_RETARGET_EN.
- Defined: cfg_ready=1 in RAMP as well. An accept during RAMP replaces target, step_div and pending_fv and clears the step counter, without changing duty_out. If the new target equals duty_out, the controller goes to IDLE with a done pulse next cycle.
- Undefined: cfg_ready=0 while busy, and requests stall until the ramp completes.

Test Plan:
- Reset release: reset low then high → duty_out=0, final_value_out=0, cfg_ready=1, busy=0, done=0.
- BITS=4, fv=0, step_div=0, target=3 from 0 → duty_out becomes 1, 2, 3 at boundaries spaced 16 cycles apart; done pulses once; busy deasserts together with the done pulse.
- fv=1, step_div=2, target=2 from 0 → period is 32 cycles; duty_out=1 after the 3rd boundary and 2 after the 6th.
- Ramp down then clamp: target=31 from 0 with BITS=4 → duty_out saturates at 16 and done fires. Then target=14 → duty_out goes 15, then 14.
- enable held low for 50 cycles mid-ramp → no output or counter change during the hold; the remaining step timing is resumed exactly afterwards.
- Reset pulse mid-ramp → immediate reset values. With PWM_RAMP_RETARGET_EN, a retarget to 5 while ramping up at duty_out=8 → duty_out ramps down to 5 instead.
